// File: rtl/puf_pkg.sv
// Shared types and constants for the RO-PUF race arbiter.
// Optional build macro PUF_TIE_RETRY_EN enables rerunning tied races.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RACE   = 3'd2,
        DECIDE = 3'd3,
        DONE   = 3'd4
    } puf_state_e;

    localparam int unsigned TIE_RETRIES = 3;

    // Response bit encodings; ties and timeouts resolve to the B-win value.
    localparam logic BIT_A_WIN  = 1'b1;
    localparam logic BIT_B_WIN  = 1'b0;
    localparam logic BIT_NO_WIN = 1'b0;

endpackage

// File: rtl/puf_race_timer.sv
// Loadable saturating down-counter used for CLEAR settle time and RACE timeout.
// expired is registered and high whenever the count sits at zero.
module puf_race_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] r_cnt;
    logic         r_expired;
    logic [W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load) begin
            w_cnt_nxt = value;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_expired <= 1'b1;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_expired <= (w_cnt_nxt == '0);
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/puf_race_arbiter.sv
// RO-PUF sequencer: runs one counter race per response bit and returns the bits over valid/ready.
// Define PUF_TIE_RETRY_EN to rerun tied races up to TIE_RETRIES times per bit.
module puf_race_arbiter
    import puf_pkg::*;
#(
    parameter int unsigned RESP_W  = 8,
    parameter int unsigned CHAL_W  = 4,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic              busy,
    output logic [CHAL_W-1:0] pair_sel,
    output logic              ro_en,
    output logic              cnt_rst,
    input  logic              fin_a,
    input  logic              fin_b,
    output logic [RESP_W-1:0] response,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              timeout_err
);

    localparam int unsigned IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int unsigned TMR_T_W = $clog2(TIMEOUT + 1);
    localparam int unsigned TMR_S_W = $clog2(SETTLE + 1);
    localparam int unsigned TMR_W   = (TMR_T_W > TMR_S_W) ? TMR_T_W : TMR_S_W;

    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RESP_W - 1);

    puf_state_e        r_state;
    logic [CHAL_W-1:0] r_chal;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_bit;
    logic              r_busy;
    logic [CHAL_W-1:0] r_pair_sel;
    logic              r_ro_en;
    logic              r_cnt_rst;
    logic [RESP_W-1:0] r_response;
    logic              r_resp_valid;
    logic              r_timeout_err;

    puf_state_e        w_state_nxt;
    logic [CHAL_W-1:0] w_chal_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_bit_nxt;
    logic [RESP_W-1:0] w_resp_nxt;
    logic              w_terr_nxt;
    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_value;
    logic              w_tmr_expired;
    logic              w_tie;

`ifdef PUF_TIE_RETRY_EN
    localparam int unsigned RETRY_W = $clog2(TIE_RETRIES + 1);
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
`endif

    assign w_tie = fin_a & fin_b;

    puf_race_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_tmr_load),
        .value   (w_tmr_value),
        .expired (w_tmr_expired)
    );

    // Next-state and datapath decode; timer reloads on every entry to CLEAR or RACE.
    always_comb begin
        w_state_nxt = r_state;
        w_chal_nxt  = r_chal;
        w_idx_nxt   = r_bit_idx;
        w_bit_nxt   = r_bit;
        w_resp_nxt  = r_response;
        w_terr_nxt  = r_timeout_err;
        w_tmr_load  = 1'b0;
        w_tmr_value = SETTLE_LD;
`ifdef PUF_TIE_RETRY_EN
        w_retry_nxt = r_retry;
`endif

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_chal_nxt  = challenge;
                    w_idx_nxt   = '0;
                    w_resp_nxt  = '0;
                    w_terr_nxt  = 1'b0;
                    w_state_nxt = CLEAR;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = SETTLE_LD;
`ifdef PUF_TIE_RETRY_EN
                    w_retry_nxt = '0;
`endif
                end
            end
            CLEAR: begin
                if (w_tmr_expired) begin
                    w_state_nxt = RACE;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMEOUT_LD;
                end
            end
            RACE: begin
                if (fin_a ^ fin_b) begin
                    w_bit_nxt   = fin_a ? BIT_A_WIN : BIT_B_WIN;
                    w_state_nxt = DECIDE;
                end else if (w_tie) begin
                    w_bit_nxt   = BIT_NO_WIN;
                    w_state_nxt = DECIDE;
`ifdef PUF_TIE_RETRY_EN
                    if (r_retry < RETRY_W'(TIE_RETRIES)) begin
                        w_retry_nxt = r_retry + RETRY_W'(1);
                        w_state_nxt = CLEAR;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = SETTLE_LD;
                    end
`endif
                end else if (w_tmr_expired) begin
                    w_bit_nxt   = BIT_NO_WIN;
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                w_resp_nxt[r_bit_idx] = r_bit;
`ifdef PUF_TIE_RETRY_EN
                w_retry_nxt = '0;
`endif
                if (r_bit_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt   = r_bit_idx + IDX_W'(1);
                    w_state_nxt = CLEAR;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = SETTLE_LD;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output flops are decoded from the next state so each output tracks its state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_chal        <= '0;
            r_bit_idx     <= '0;
            r_bit         <= 1'b0;
            r_busy        <= 1'b0;
            r_pair_sel    <= '0;
            r_ro_en       <= 1'b0;
            r_cnt_rst     <= 1'b1;
            r_response    <= '0;
            r_resp_valid  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_chal        <= w_chal_nxt;
            r_bit_idx     <= w_idx_nxt;
            r_bit         <= w_bit_nxt;
            r_busy        <= (w_state_nxt != IDLE);
            r_pair_sel    <= CHAL_W'(w_chal_nxt + CHAL_W'(w_idx_nxt));
            r_ro_en       <= (w_state_nxt == RACE);
            r_cnt_rst     <= (w_state_nxt != RACE);
            r_response    <= w_resp_nxt;
            r_resp_valid  <= (w_state_nxt == DONE);
            r_timeout_err <= w_terr_nxt;
        end
    end

`ifdef PUF_TIE_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry <= '0;
        end else begin
            r_retry <= w_retry_nxt;
        end
    end
`endif

    assign busy        = r_busy;
    assign pair_sel    = r_pair_sel;
    assign ro_en       = r_ro_en;
    assign cnt_rst     = r_cnt_rst;
    assign response    = r_response;
    assign resp_valid  = r_resp_valid;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_puf_race_arbiter.sv
// Scoreboard bench for puf_race_arbiter: race plans drive fin pulses, a monitor checks responses.
module tb_puf_race_arbiter;

    localparam int unsigned RESP_W  = 8;
    localparam int unsigned CHAL_W  = 4;
    localparam int          TIMEOUT = 1023;

    typedef enum int {K_A, K_B, K_TIE, K_NONE} kind_e;
    typedef struct {
        kind_e kind;
        int    delay;
        bit    trail;
    } plan_t;
    typedef struct {
        logic [RESP_W-1:0] resp;
        logic              terr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CHAL_W-1:0] challenge = '0;
    logic              fin_a = 1'b0;
    logic              fin_b = 1'b0;
    logic              resp_ready = 1'b0;
    logic              busy;
    logic [CHAL_W-1:0] pair_sel;
    logic              ro_en;
    logic              cnt_rst;
    logic [RESP_W-1:0] response;
    logic              resp_valid;
    logic              timeout_err;

    int    n_vec = 0;
    int    n_err = 0;
    int    race_cnt = 0;
    bit    hold_ready = 1'b0;
    bit    aborting = 1'b0;
    plan_t plan_q[$];
    logic [CHAL_W-1:0] pair_q[$];
    exp_t  exp_q[$];

    puf_race_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .challenge   (challenge),
        .busy        (busy),
        .pair_sel    (pair_sel),
        .ro_en       (ro_en),
        .cnt_rst     (cnt_rst),
        .fin_a       (fin_a),
        .fin_b       (fin_b),
        .response    (response),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Consumer: random ready, forced low while a hold is requested.
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Counter model: executes one queued plan per observed race.
    initial begin : race_drv
        plan_t             p;
        logic [CHAL_W-1:0] ep;
        int                n;
        forever begin
            @(negedge clk);
            if (ro_en === 1'b1) begin
                race_cnt++;
                if (plan_q.size() == 0) begin
                    check("race_unplanned", 32'(1), 32'(0));
                    n = 0;
                    while (ro_en === 1'b1 && n < 2000) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    p  = plan_q.pop_front();
                    ep = pair_q.pop_front();
                    check("pair_sel", 32'(pair_sel), 32'(ep));
                    if (p.kind == K_NONE) begin
                        n = 1;
                        while (ro_en === 1'b1 && n < 2000) begin
                            @(negedge clk);
                            if (ro_en === 1'b1) n++;
                        end
                        if (!aborting) check("timeout_len", 32'(n), 32'(TIMEOUT));
                    end else begin
                        repeat (p.delay) @(negedge clk);
                        fin_a = (p.kind != K_B);
                        fin_b = (p.kind != K_A);
                        @(negedge clk);
                        fin_a = 1'b0;
                        fin_b = 1'b0;
                        check("ro_en_after_fin", 32'(ro_en), 32'(0));
                        if (p.trail) begin
                            repeat (4) @(negedge clk);
                            fin_a = (p.kind == K_B);
                            fin_b = (p.kind == K_A);
                            @(negedge clk);
                            fin_a = 1'b0;
                            fin_b = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: protocol checks each cycle, scoreboard pop on every handshake.
    initial begin : monitor
        logic              pv;
        logic [RESP_W-1:0] pr;
        exp_t              e;
        pv = 1'b0;
        pr = '0;
        forever begin
            @(negedge clk);
            if (ro_en === 1'b1) check("cnt_rst_in_race", 32'(cnt_rst), 32'(0));
            if (resp_valid === 1'b1 && pv) check("resp_stable", 32'(response), 32'(pr));
            if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("response", 32'(response), 32'(e.resp));
                    check("timeout_err", 32'(timeout_err), 32'(e.terr));
                end
            end
            pv = (resp_valid === 1'b1) && (resp_ready !== 1'b1);
            pr = response;
        end
    end

    // Builds the race plans for one challenge, predicts the response, then issues start.
    task automatic run_txn(input logic [CHAL_W-1:0] chal, input int mode,
                           input bit repulse, input bit hold, input bit wait_done);
        exp_t  e;
        plan_t p;
        int    idx;
        int    retries;
        int    n;
        bit    redo;
        logic  b;
        e.resp  = '0;
        e.terr  = 1'b0;
        idx     = 0;
        retries = 0;
        while (idx < int'(RESP_W)) begin
            p.delay = $urandom_range(0, 12);
            p.trail = 1'b0;
            case (mode)
                1: begin p.kind = K_A; p.trail = 1'b1; end
                2: begin p.kind = (idx % 2 == 0) ? K_B : K_A; p.trail = 1'b1; end
                3: p.kind = (idx == 2) ? K_NONE : K_A;
                4: p.kind = (idx == 0 && retries == 0) ? K_TIE : K_A;
                5: p.kind = (idx == 4) ? K_NONE : K_A;
                default: begin
                    n = $urandom_range(0, 9);
                    p.kind  = (n < 4) ? K_A : (n < 8) ? K_B : K_TIE;
                    p.trail = (n < 8) && ($urandom_range(0, 1) == 1);
                end
            endcase
            plan_q.push_back(p);
            pair_q.push_back(CHAL_W'(chal + idx));
            redo = 1'b0;
            b    = 1'b0;
            case (p.kind)
                K_A:    b = 1'b1;
                K_B:    b = 1'b0;
                K_NONE: begin b = 1'b0; e.terr = 1'b1; end
                default: begin
`ifdef PUF_TIE_RETRY_EN
                    if (retries < 3) begin
                        retries++;
                        redo = 1'b1;
                    end
`endif
                    b = 1'b0;
                end
            endcase
            if (!redo) begin
                e.resp[idx] = b;
                idx++;
                retries = 0;
            end
        end
        exp_q.push_back(e);

        @(negedge clk);
        challenge = chal;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        challenge = CHAL_W'($urandom);
        check("busy_after_start", 32'(busy), 32'(1));
        check("terr_cleared", 32'(timeout_err), 32'(0));
        if (repulse) begin
            repeat (2) @(negedge clk);
            start     = 1'b1;
            challenge = ~chal;
            @(negedge clk);
            start     = 1'b0;
        end
        if (hold) begin
            n = 0;
            while (resp_valid !== 1'b1 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("valid_seen", 32'(resp_valid), 32'(1));
            repeat (10) @(negedge clk);
            check("valid_held", 32'(resp_valid), 32'(1));
            hold_ready = 1'b0;
        end
        if (wait_done) begin
            n = 0;
            while (busy !== 1'b0 && n < 12000) begin
                @(negedge clk);
                n++;
            end
            check("busy_drop", 32'(busy), 32'(0));
        end
    endtask

    initial begin : stim
        int base;
        int n;
        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ro_en", 32'(ro_en), 32'(0));
        check("rst_cnt_rst", 32'(cnt_rst), 32'(1));
        check("rst_pair_sel", 32'(pair_sel), 32'(0));
        check("rst_response", 32'(response), 32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_timeout_err", 32'(timeout_err), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(4'h3, 1, 1'b0, 1'b0, 1'b1);
        hold_ready = 1'b1;
        run_txn(CHAL_W'($urandom), 2, 1'b0, 1'b1, 1'b1);
        run_txn(CHAL_W'($urandom), 3, 1'b0, 1'b0, 1'b1);
        run_txn(CHAL_W'($urandom), 1, 1'b0, 1'b0, 1'b1);
        run_txn(CHAL_W'($urandom), 4, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of the bit-4 race.
        base = race_cnt;
        run_txn(CHAL_W'($urandom), 5, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (race_cnt - base < 5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("race4_reached", 32'(race_cnt - base), 32'(5));
        repeat (10) @(negedge clk);
        aborting = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("midrst_ro_en", 32'(ro_en), 32'(0));
        check("midrst_cnt_rst", 32'(cnt_rst), 32'(1));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_resp_valid", 32'(resp_valid), 32'(0));
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        plan_q.delete();
        pair_q.delete();
        aborting = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(CHAL_W'($urandom), 1, 1'b0, 1'b0, 1'b1);
        run_txn(4'hE, 1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) begin
            run_txn(CHAL_W'($urandom), 0, ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
        end

        repeat (30) @(negedge clk);
        check("plans_consumed", 32'(plan_q.size()), 32'(0));
        check("responses_seen", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
